// File: rtl/joy_dig2ana_if.sv
// joy_dig2ana_if -- joystick bundle between the swap mux and the CoCo3
// analog joystick ports.
//   joy_dig  : {up,down,left,right} d-pad bits, active-high
//   joy_ana  : {Y[15:8], X[7:0]} signed stick, 0 = centre
//   ajoy     : {X[15:8], Y[7:0]} unsigned, 128 = centre
//   ana_mode : 1 = ajoy follows the stick, 0 = ajoy follows the d-pad ramp
// master drives the joystick inputs; slave is the converter.
interface joy_dig2ana_if;
    logic [3:0]  joy_dig;
    logic [15:0] joy_ana;
    logic [15:0] ajoy;
    logic        ana_mode;

    modport master (
        output joy_dig,
        output joy_ana,
        input  ajoy,
        input  ana_mode
    );

    modport slave (
        input  joy_dig,
        input  joy_ana,
        output ajoy,
        output ana_mode
    );
endinterface

// File: rtl/joy_dig2ana.sv
// joy_dig2ana -- converts one MiSTer joystick (d-pad + signed stick) into the
// unsigned 128-centred X/Y byte pair expected by the CoCo3 analog inputs.
// D-pad directions drive a rate-limited ramp with auto-centre; a two-state
// mode FSM selects between the stick and the ramp.
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high
//   bus    : joy_dig2ana_if.slave (joy_dig, joy_ana in; ajoy, ana_mode out)
module joy_dig2ana #(
    parameter int unsigned TICK_DIV    = 50000,
    parameter int unsigned STEP        = 4,
    parameter int unsigned RETURN_STEP = 8,
    parameter int unsigned DEADZONE    = 16
) (
    input  logic          clk,
    input  logic          reset,
    joy_dig2ana_if.slave  bus
);

    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic {
        DIG = 1'b0,
        ANA = 1'b1
    } mode_t;

    mode_t            state_q, state_d;
    logic [DIV_W-1:0] div_q;
    logic             tick;

    logic [7:0]       pos_x_q, pos_y_q;
    logic [7:0]       pos_x_d, pos_y_d;
    logic [15:0]      ajoy_q, ajoy_d;
    logic             ana_mode_q, ana_mode_d;

    logic             up, down, left, right, dig_any;
    logic [7:0]       s_x, s_y;
    logic [7:0]       aval_x, aval_y;
    logic             ana_act;

    // 9-bit magnitude of an 8-bit two's-complement value; -128 gives 128.
    function automatic logic [8:0] mag9(input logic [7:0] s);
        logic [8:0] e;
        e = {s[7], s};
        return s[7] ? (~e + 9'd1) : e;
    endfunction

    // One tick of the digital ramp for a single axis.
    function automatic logic [7:0] ramp_axis(
        input logic [7:0] p,
        input logic       inc,
        input logic       dec
    );
        logic [9:0] w;
        w = {2'b00, p};
        if (inc && !dec) begin
            w = w + 10'(STEP);
            return (w > 10'd255) ? 8'hFF : w[7:0];
        end else if (dec && !inc) begin
            return (w < 10'(STEP)) ? 8'h00 : 8'(w - 10'(STEP));
        end else if (w > 10'(128 + RETURN_STEP)) begin
            return 8'(w - 10'(RETURN_STEP));
        end else if ((w + 10'(RETURN_STEP)) < 10'd128) begin
            return 8'(w + 10'(RETURN_STEP));
        end else begin
            // Within one return step of centre: snap, never overshoot.
            return 8'd128;
        end
    endfunction

    assign up      = bus.joy_dig[3];
    assign down    = bus.joy_dig[2];
    assign left    = bus.joy_dig[1];
    assign right   = bus.joy_dig[0];
    assign dig_any = |bus.joy_dig;

    assign s_x = bus.joy_ana[7:0];
    assign s_y = bus.joy_ana[15:8];

    // Flipping the sign bit is the same as adding 128.
    assign aval_x = {~s_x[7], s_x[6:0]};
    assign aval_y = {~s_y[7], s_y[6:0]};

    assign ana_act = (mag9(s_x) > 9'(DEADZONE)) || (mag9(s_y) > 9'(DEADZONE));

    assign tick = (div_q == DIV_W'(TICK_DIV - 1));

    always_comb begin
        state_d = state_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;

        case (state_q)
            DIG: begin
                if (tick) begin
                    pos_x_d = ramp_axis(pos_x_q, right, left);
                    pos_y_d = ramp_axis(pos_y_q, down, up);
                end
                if (ana_act && !dig_any) begin
                    state_d = ANA;
                end
            end
            ANA: begin
                // Hand over to the ramp from wherever the stick was.
                if (dig_any) begin
                    state_d = DIG;
                    pos_x_d = aval_x;
                    pos_y_d = aval_y;
                end
            end
            default: begin
                state_d = DIG;
            end
        endcase

        // Outputs are registered from the post-edge state.
        ana_mode_d = (state_d == ANA);
        ajoy_d     = (state_d == ANA) ? {aval_x, aval_y} : {pos_x_d, pos_y_d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q      <= '0;
            state_q    <= DIG;
            pos_x_q    <= 8'd128;
            pos_y_q    <= 8'd128;
            ajoy_q     <= 16'h8080;
            ana_mode_q <= 1'b0;
        end else begin
            div_q      <= tick ? '0 : div_q + DIV_W'(1);
            state_q    <= state_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            ajoy_q     <= ajoy_d;
            ana_mode_q <= ana_mode_d;
        end
    end

    assign bus.ajoy     = ajoy_q;
    assign bus.ana_mode = ana_mode_q;

endmodule

// File: tb/tb_joy_dig2ana.sv
// tb_joy_dig2ana -- directed bench for joy_dig2ana with a behavioural model
// of the stick/ramp selection checked every cycle, plus literal expectations.
module tb_joy_dig2ana;

    localparam int TD = 4;
    localparam int ST = 4;
    localparam int RS = 8;
    localparam int DZ = 16;

    logic clk;
    logic reset;

    joy_dig2ana_if bus ();

    joy_dig2ana #(
        .TICK_DIV   (TD),
        .STEP       (ST),
        .RETURN_STEP(RS),
        .DEADZONE   (DZ)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_cnt;
    int          m_px, m_py;
    bit          m_ana;
    bit          m_valid = 1'b0;
    logic [15:0] exp_ajoy;
    logic        exp_mode;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int step_axis(input int p, input bit inc, input bit dec);
        int d;
        if (inc && !dec) return (p + ST > 255) ? 255 : p + ST;
        if (dec && !inc) return (p - ST < 0) ? 0 : p - ST;
        d = p - 128;
        if (iabs(d) <= RS) return 128;
        return (d > 0) ? p - RS : p + RS;
    endfunction

    always @(posedge clk) begin
        int sx, sy;
        bit tk, act;
        if (reset) begin
            m_cnt    = 0;
            m_px     = 128;
            m_py     = 128;
            m_ana    = 1'b0;
            exp_ajoy = 16'h8080;
            exp_mode = 1'b0;
            m_valid  = 1'b1;
        end else begin
            sx    = int'($signed(bus.joy_ana[7:0]));
            sy    = int'($signed(bus.joy_ana[15:8]));
            tk    = (m_cnt == TD - 1);
            m_cnt = (m_cnt + 1) % TD;
            act   = (iabs(sx) > DZ) || (iabs(sy) > DZ);
            if (!m_ana) begin
                if (tk) begin
                    m_px = step_axis(m_px, bus.joy_dig[0], bus.joy_dig[1]);
                    m_py = step_axis(m_py, bus.joy_dig[2], bus.joy_dig[3]);
                end
                if (act && bus.joy_dig == 4'd0) m_ana = 1'b1;
            end else if (bus.joy_dig != 4'd0) begin
                m_ana = 1'b0;
                m_px  = 128 + sx;
                m_py  = 128 + sy;
            end
            exp_mode = m_ana;
            exp_ajoy = m_ana ? {8'(128 + sx), 8'(128 + sy)} : {8'(m_px), 8'(m_py)};
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_ajoy", bus.ajoy, exp_ajoy);
            chk("model_ana_mode", {15'd0, bus.ana_mode}, {15'd0, exp_mode});
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic lit(input string name, input logic [15:0] aj, input logic md);
        chk({name, "_ajoy"}, bus.ajoy, aj);
        chk({name, "_mode"}, {15'd0, bus.ana_mode}, {15'd0, md});
    endtask

    task automatic pulse_reset(input logic [3:0] dig_after, input logic [15:0] ana_after);
        reset = 1'b1;
        cyc(1);
        reset       = 1'b0;
        bus.joy_dig = dig_after;
        bus.joy_ana = ana_after;
    endtask

    initial begin
        reset       = 1'b1;
        bus.joy_dig = 4'd0;
        bus.joy_ana = 16'd0;
        cyc(2);
        reset = 1'b0;

        // 1: idle
        cyc(40);
        lit("t1_idle", 16'h8080, 1'b0);

        // 2: hold right from reset, saturate, release, opposing cancel
        pulse_reset(4'b0001, 16'd0);
        cyc(TD);
        lit("t2_first_step", 16'h8480, 1'b0);
        cyc(31 * TD);
        lit("t2_saturate", 16'hFF80, 1'b0);
        cyc(8 * TD);
        lit("t2_hold_sat", 16'hFF80, 1'b0);
        bus.joy_dig = 4'b0000;
        cyc(TD);
        lit("t2_return1", 16'hF780, 1'b0);
        cyc(TD);
        lit("t2_return2", 16'hEF80, 1'b0);
        cyc(20 * TD);
        lit("t2_centred", 16'h8080, 1'b0);
        bus.joy_dig = 4'b0001;
        cyc(10 * TD);
        lit("t2_x168", 16'hA880, 1'b0);
        bus.joy_dig = 4'b0011;
        cyc(5 * TD);
        lit("t2_lr_cancel", 16'h8080, 1'b0);

        // 3: up saturates at 0, diagonal up+left
        bus.joy_dig = 4'b1000;
        cyc(40 * TD);
        lit("t3_up_sat", 16'h8000, 1'b0);
        bus.joy_dig = 4'b0000;
        cyc(16 * TD);
        lit("t3_y_back", 16'h8080, 1'b0);
        bus.joy_dig = 4'b1010;
        cyc(5 * TD);
        lit("t3_diag", 16'h6C6C, 1'b0);
        bus.joy_dig = 4'b0000;
        cyc(3 * TD);
        lit("t3_diag_back", 16'h8080, 1'b0);

        // 4: analog deadzone, selection and extremes
        bus.joy_ana = {8'h00, 8'd10};
        cyc(3);
        lit("t4_inside_dz", 16'h8080, 1'b0);
        bus.joy_ana = {8'h00, 8'd100};
        cyc(1);
        lit("t4_ana_x228", 16'hE480, 1'b1);
        bus.joy_ana = {8'h00, 8'h80};
        cyc(1);
        lit("t4_x_min", 16'h0080, 1'b1);
        bus.joy_ana = {8'h7F, 8'h80};
        cyc(1);
        lit("t4_y_max", 16'h00FF, 1'b1);
        bus.joy_ana = {8'h00, 8'd5};
        cyc(2);
        lit("t4_sticky_ana", 16'h8580, 1'b1);
        bus.joy_ana = {8'h00, 8'd100};
        cyc(1);
        lit("t4_ana_again", 16'hE480, 1'b1);

        // 5: d-pad takes over from the stick position
        bus.joy_dig = 4'b0001;
        cyc(1);
        lit("t5_handover", 16'hE480, 1'b0);
        cyc(TD);
        lit("t5_ramp_on", 16'hE880, 1'b0);
        pulse_reset(4'b0001, {8'h00, 8'd100});
        cyc(1);
        lit("t5_dig_wins", 16'h8080, 1'b0);
        bus.joy_dig = 4'b0000;
        bus.joy_ana = 16'd0;
        cyc(2 * TD);

        // 6: reset mid-ramp restarts the divider
        pulse_reset(4'b0001, 16'd0);
        cyc(18 * TD);
        lit("t6_x200", 16'hC880, 1'b0);
        reset = 1'b1;
        cyc(1);
        lit("t6_reset", 16'h8080, 1'b0);
        reset = 1'b0;
        cyc(TD - 1);
        lit("t6_pre_tick", 16'h8080, 1'b0);
        cyc(1);
        lit("t6_first_tick", 16'h8480, 1'b0);

        bus.joy_dig = 4'b0000;
        cyc(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
